// File: rtl/mux_n_to_1_stream_if.sv
// Stream selector bus: N input channels plus one registered output stream.
// master = producer/consumer side (testbench, system), slave = the selector.
interface mux_n_to_1_stream_if #(
   parameter int WIDTH = 32,
   parameter int N     = 8,
   parameter int SEL_W = $clog2(N)
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic               mode;
   logic [SEL_W-1:0]   sel;
   logic [WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]   out_src;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_src, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_src, out_valid
   );
endinterface

// File: rtl/mux_n_to_1_stream.sv
// N-input registered stream selector with valid/ready handshake.
// Explicit (mode=0, sel) or round-robin (mode=1) source selection.
// Optional build macro MUX_N_SKID_EN: adds a skid slot behind the output
// register so in_ready no longer depends combinationally on out_ready.
module mux_n_to_1_stream #(
   parameter int WIDTH = 32,
   parameter int N     = 8,
   parameter int SEL_W = $clog2(N)
) (
   input logic                  clk,
   input logic                  reset_n,
   mux_n_to_1_stream_if.slave   bus
);

   localparam int unsigned NU = N;

   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] gidx;
   logic             gvalid;
   logic [WIDTH-1:0] gdata;
   logic             can_load;
   logic             load;
   logic [N-1:0]     ready_vec;
   int unsigned      rr_idx;

   logic [WIDTH-1:0] out_data_q;
   logic [SEL_W-1:0] out_src_q;
   logic             out_valid_q;

   // Grant: explicit channel or first valid channel at/after rr_ptr (wrapping)
   always_comb begin
      gvalid = 1'b0;
      gidx   = '0;
      rr_idx = 0;
      if (!bus.mode) begin
         for (int unsigned i = 0; i < NU; i++) begin
            if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
               gvalid = 1'b1;
               gidx   = SEL_W'(i);
            end
         end
      end else begin
         // Walk offsets from farthest to nearest so the nearest valid wins.
         for (int unsigned k = 0; k < NU; k++) begin
            rr_idx = (int'(rr_ptr) + (NU - 1 - k)) % NU;
            if (bus.in_valid[rr_idx]) begin
               gvalid = 1'b1;
               gidx   = SEL_W'(rr_idx);
            end
         end
      end
   end

   // Granted word, handshake qualifiers and one-hot ready
   always_comb begin
      gdata     = bus.in_data[int'(gidx)*WIDTH +: WIDTH];
      load      = reset_n & gvalid & can_load;
      ready_vec = '0;
      if (load) ready_vec[gidx] = 1'b1;
   end

   assign bus.in_ready  = ready_vec;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign bus.out_valid = out_valid_q;

   // Round-robin pointer: moves past the winner only on mode=1 transfers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr <= '0;
      end else if (load && bus.mode) begin
         rr_ptr <= (gidx == SEL_W'(N - 1)) ? '0 : gidx + 1'b1;
      end
   end

`ifdef MUX_N_SKID_EN
   logic             skid_full;
   logic [WIDTH-1:0] skid_data;
   logic [SEL_W-1:0] skid_src;

   assign can_load = ~skid_full;

   // Output register refills from the skid slot first; a stalled output
   // parks at most one new word in the skid slot.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
         skid_full   <= 1'b0;
         skid_data   <= '0;
         skid_src    <= '0;
      end else if (!out_valid_q || bus.out_ready) begin
         if (skid_full) begin
            out_data_q  <= skid_data;
            out_src_q   <= skid_src;
            out_valid_q <= 1'b1;
            skid_full   <= 1'b0;
         end else if (load) begin
            out_data_q  <= gdata;
            out_src_q   <= gidx;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (load) begin
         skid_data <= gdata;
         skid_src  <= gidx;
         skid_full <= 1'b1;
      end
   end
`else
   assign can_load = ~out_valid_q | bus.out_ready;

   // Single output register: load, drain, or hold while stalled
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
      end else if (load) begin
         out_data_q  <= gdata;
         out_src_q   <= gidx;
         out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Self-checking bench for mux_n_to_1_stream (N=8 and N=6 instances).
module tb_mux_n_to_1_stream;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux_n_to_1_stream_if #(.WIDTH(32), .N(8)) bus8 ();
   mux_n_to_1_stream_if #(.WIDTH(32), .N(6)) bus6 ();

   mux_n_to_1_stream #(.WIDTH(32), .N(8)) dut8 (.clk(clk), .reset_n(rst_n), .bus(bus8));
   mux_n_to_1_stream #(.WIDTH(32), .N(6)) dut6 (.clk(clk), .reset_n(rst_n), .bus(bus6));

   typedef struct {
      bit         md;
      logic [2:0] s;
      logic [7:0] v;
      bit         ordy;
      logic [7:0] exp_rdy;
   } vec_t;

   vec_t        tbl[12];
   int          total = 0;
   int          bad   = 0;
   int          stepno = 0;
   bit          m_ov;
   logic [31:0] m_od;
   logic [2:0]  m_os;
   int          m_rr;
   logic [34:0] sb[$];
   logic [7:0]  last_rdy;
   bit          ovr = 1'b0;
   int          ovr_ch = 0;
   logic [31:0] ovr_data = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int mgrant(input bit md, input int s, input logic [7:0] v,
                                 input int rr, input int n);
      if (!md) return (s < n && v[s]) ? s : -1;
      for (int k = 0; k < n; k++) begin
         if (v[(rr + k) % n]) return (rr + k) % n;
      end
      return -1;
   endfunction

   // One clock of stimulus on the N=8 instance with model + scoreboard checks.
   task automatic step(input bit md, input logic [2:0] s, input logic [7:0] v,
                       input bit ordy, input bit rn);
      int          g;
      logic [7:0]  mrdy;
      bit          ld;
      logic [34:0] e;
      logic [34:0] got;
      stepno++;
      rst_n          = rn;
      bus8.mode      = md;
      bus8.sel       = s;
      bus8.in_valid  = v;
      bus8.out_ready = ordy;
      for (int i = 0; i < 8; i++)
         bus8.in_data[i*32 +: 32] = 32'h5A00_0000 + 32'(stepno) * 256 + 32'(i);
      if (ovr) bus8.in_data[ovr_ch*32 +: 32] = ovr_data;
      #1;
      g    = mgrant(md, int'(s), v, m_rr, 8);
      mrdy = (rn && g >= 0 && (!m_ov || ordy)) ? 8'(1 << g) : 8'h00;
      last_rdy = bus8.in_ready;
      chk("in_ready", 32'(bus8.in_ready), 32'(mrdy));
      ld = (mrdy != 8'h00);
      e  = '0;
      if (ld) e = {3'(g), bus8.in_data[g*32 +: 32]};
      @(posedge clk);
      #1;
      if (!rn) begin
         m_ov = 1'b0; m_od = '0; m_os = '0; m_rr = 0;
         sb.delete();
      end else if (ld) begin
         sb.push_back(e);
         m_ov = 1'b1; m_od = e[31:0]; m_os = e[34:32];
         if (md) m_rr = (g + 1) % 8;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      chk("out_valid", 32'(bus8.out_valid), 32'(m_ov));
      if (!rn) begin
         chk("reset_data", bus8.out_data, 32'h0);
         chk("reset_src", 32'(bus8.out_src), 32'h0);
      end else if (ld) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            got = sb.pop_front();
            chk("sb_data", bus8.out_data, got[31:0]);
            chk("sb_src", 32'(bus8.out_src), 32'(got[34:32]));
         end
      end else if (m_ov) begin
         chk("hold_data", bus8.out_data, m_od);
         chk("hold_src", 32'(bus8.out_src), 32'(m_os));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      m_ov = 1'b0; m_od = '0; m_os = '0; m_rr = 0;
      bus8.in_data = '0; bus8.in_valid = '0; bus8.mode = 1'b0;
      bus8.sel = '0; bus8.out_ready = 1'b1;
      bus6.in_data = '0; bus6.in_valid = '0; bus6.mode = 1'b0;
      bus6.sel = '0; bus6.out_ready = 1'b1;

      // {mode, sel, in_valid, out_ready, expected in_ready} starting from rr_ptr=0
      tbl[0]  = '{1'b0, 3'd5, 8'h20, 1'b1, 8'h20};
      tbl[1]  = '{1'b0, 3'd3, 8'h20, 1'b1, 8'h00};
      tbl[2]  = '{1'b0, 3'd3, 8'hFF, 1'b1, 8'h08};
      tbl[3]  = '{1'b1, 3'd0, 8'h05, 1'b1, 8'h01};
      tbl[4]  = '{1'b1, 3'd0, 8'h05, 1'b1, 8'h04};
      tbl[5]  = '{1'b1, 3'd0, 8'h05, 1'b1, 8'h01};
      tbl[6]  = '{1'b1, 3'd0, 8'h05, 1'b1, 8'h04};
      tbl[7]  = '{1'b1, 3'd0, 8'h05, 1'b1, 8'h01};
      tbl[8]  = '{1'b1, 3'd0, 8'h00, 1'b1, 8'h00};
      tbl[9]  = '{1'b0, 3'd7, 8'h80, 1'b1, 8'h80};
      tbl[10] = '{1'b1, 3'd0, 8'h81, 1'b1, 8'h80};
      tbl[11] = '{1'b1, 3'd0, 8'h81, 1'b1, 8'h01};

      @(posedge clk);
      #1;
      step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);

      // Table vectors
      for (int i = 0; i < 12; i++) begin
         if (i == 0) begin
            ovr = 1'b1; ovr_ch = 5; ovr_data = 32'hDEADBEEF;
         end
         step(tbl[i].md, tbl[i].s, tbl[i].v, tbl[i].ordy, 1'b1);
         chk("tbl_in_ready", 32'(last_rdy), 32'(tbl[i].exp_rdy));
         if (i == 0) begin
            chk("t1_data", bus8.out_data, 32'hDEADBEEF);
            chk("t1_src", 32'(bus8.out_src), 32'd5);
            ovr = 1'b0;
         end
      end

      // Round-robin across all valid channels, one word per cycle
      step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 3'd0, 8'hFF, 1'b1, 1'b1);
         chk("rr_seq_src", 32'(bus8.out_src), 32'(k % 8));
         chk("rr_seq_valid", 32'(bus8.out_valid), 32'd1);
      end

      // Stall while ch2 stays valid, then resume without loss or duplication
      step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 3'd2, 8'h04, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 3'd2, 8'h04, 1'b0, 1'b1);
         chk("stall_in_ready", 32'(last_rdy), 32'h0);
      end
      step(1'b0, 3'd2, 8'h04, 1'b1, 1'b1);
      chk("resume_accept", 32'(last_rdy), 32'h04);
      step(1'b0, 3'd2, 8'h00, 1'b1, 1'b1);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("drained", 32'(bus8.out_valid), 32'd0);

      // N=6: out-of-range select never grants
      bus6.mode = 1'b0; bus6.sel = 3'd7; bus6.in_valid = 6'h3F; bus6.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) bus6.in_data[i*32 +: 32] = 32'h6600_0000 + 32'(i);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("n6_sel7_in_ready", 32'(bus6.in_ready), 32'h0);
         step(1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
         chk("n6_sel7_out_valid", 32'(bus6.out_valid), 32'd0);
      end
      bus6.sel = 3'd5;
      #1;
      chk("n6_sel5_in_ready", 32'(bus6.in_ready), 32'h20);
      step(1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
      chk("n6_sel5_valid", 32'(bus6.out_valid), 32'd1);
      chk("n6_sel5_src", 32'(bus6.out_src), 32'd5);
      chk("n6_sel5_data", bus6.out_data, 32'h6600_0005);
      bus6.in_valid = '0;

      // Reset while holding a stalled word; round-robin restarts at ch0
      step(1'b1, 3'd0, 8'h10, 1'b1, 1'b1);
      step(1'b1, 3'd0, 8'h10, 1'b0, 1'b1);
      chk("pre_reset_valid", 32'(bus8.out_valid), 32'd1);
      step(1'b1, 3'd0, 8'hFF, 1'b0, 1'b0);
      chk("reset_in_ready", 32'(last_rdy), 32'h0);
      chk("reset_out_valid", 32'(bus8.out_valid), 32'd0);
      step(1'b1, 3'd0, 8'hFF, 1'b1, 1'b1);
      chk("post_reset_grant", 32'(last_rdy), 32'h01);
      chk("post_reset_src", 32'(bus8.out_src), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
